// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: instruction encodings,
// FSM states and default iteration count.
package mul_pkg;

  localparam int MUL_ITERS = 16;

  typedef enum logic [1:0] {
    MT_MULI  = 2'd0,
    MT_MULR  = 2'd1,
    MT_MULSI = 2'd2,
    MT_MULSR = 2'd3
  } mul_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_SIGN = 2'd2,
    S_WB   = 2'd3
  } mul_state_e;

  function automatic logic is_signed_type(input logic [1:0] t);
    return (t == MT_MULSI) || (t == MT_MULSR);
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Decode/writeback bus between the pipeline and the multiply sequencer.
interface mul_sequencer_if
  import mul_pkg::*;
#(
  parameter int MUL_W = MUL_ITERS
);
  logic               mul_trigger;
  logic [1:0]         mul_type;
  logic [3:0]         dest_reg;
  logic [MUL_W-1:0]   op_a;
  logic [MUL_W-1:0]   op_b;
  logic               set_flags;
  logic               flush;
  logic               stall;
  logic               busy;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic [MUL_W-1:0]   wr_data;
  logic [2*MUL_W-1:0] product;
  logic               flag_we;
  logic               flag_z;
  logic               flag_n;

  modport master (
    output mul_trigger, mul_type, dest_reg, op_a, op_b, set_flags, flush,
    input  stall, busy, wr_en, wr_addr, wr_data, product, flag_we, flag_z, flag_n
  );

  modport slave (
    input  mul_trigger, mul_type, dest_reg, op_a, op_b, set_flags, flush,
    output stall, busy, wr_en, wr_addr, wr_data, product, flag_we, flag_z, flag_n
  );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: unsigned magnitude multiply, one partial product per
// step, with an optional two's-complement negate on the result.
module mul_shift_add_dp #(
  parameter int MUL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_neg,
  input  logic [MUL_W-1:0]   i_a,
  input  logic [MUL_W-1:0]   i_b,
  output logic [2*MUL_W:0]   o_result
);
  localparam int AW = 2 * MUL_W + 1;

  logic [AW-1:0]      r_acc;
  logic [2*MUL_W-1:0] r_mcand;
  logic [MUL_W-1:0]   r_mplier;
  logic               r_neg;

  // Load operands on accept, then add the shifted multiplicand per multiplier bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= {{MUL_W{1'b0}}, i_a};
      r_mplier <= i_b;
      r_neg    <= i_neg;
    end else if (i_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + {1'b0, r_mcand};
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Sign fix-up applied to the full-width accumulator
  always_comb begin
    o_result = r_neg ? (~r_acc + AW'(1)) : r_acc;
  end
endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer: accepts a multiply from decode, runs
// MUL_W shift-add steps, fixes the sign, then writes back for one cycle.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int MUL_W = MUL_ITERS
) (
  input  logic           clk,
  input  logic           rst,
  mul_sequencer_if.slave bus
);
  localparam logic [4:0] LAST_CNT = 5'(MUL_W - 1);

  mul_state_e         r_state;
  mul_state_e         w_next;
  logic [4:0]         r_cnt;
  logic [3:0]         r_dest;
  logic               r_set_flags;
  logic [2*MUL_W-1:0] r_product;
  logic               r_flag_z;
  logic               r_flag_n;

  logic               w_accept;
  logic               w_step;
  logic               w_commit;
  logic               w_signed;
  logic               w_neg;
  logic [MUL_W-1:0]   w_a_mag;
  logic [MUL_W-1:0]   w_b_mag;
  logic [2*MUL_W:0]   w_result;

  // Operand conditioning: signed types pass magnitudes plus a result-sign bit
  always_comb begin
    w_signed = is_signed_type(bus.mul_type);
    w_a_mag  = (w_signed && bus.op_a[MUL_W-1]) ? (~bus.op_a + MUL_W'(1)) : bus.op_a;
    w_b_mag  = (w_signed && bus.op_b[MUL_W-1]) ? (~bus.op_b + MUL_W'(1)) : bus.op_b;
    w_neg    = w_signed && (bus.op_a[MUL_W-1] ^ bus.op_b[MUL_W-1]);
  end

  mul_shift_add_dp #(.MUL_W(MUL_W)) u_dp (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_neg    (w_neg),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_result (w_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and control strobes; flush aborts ITER/SIGN but not WB
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.mul_trigger && !bus.flush) begin
          w_accept = 1'b1;
          w_next   = S_ITER;
        end
      end
      S_ITER: begin
        if (bus.flush) begin
          w_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == LAST_CNT) w_next = S_SIGN;
        end
      end
      S_SIGN: begin
        if (bus.flush) begin
          w_next = S_IDLE;
        end else begin
          w_commit = 1'b1;
          w_next   = S_WB;
        end
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Iteration counter, latched request fields and the committed result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_dest      <= '0;
      r_set_flags <= 1'b0;
      r_product   <= '0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt       <= '0;
        r_dest      <= bus.dest_reg;
        r_set_flags <= bus.set_flags;
      end else if (w_step) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_commit) begin
        r_product <= w_result[2*MUL_W-1:0];
        r_flag_z  <= (w_result == '0);
        r_flag_n  <= w_result[2*MUL_W-1];
      end
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.stall   = (r_state != S_IDLE) || bus.mul_trigger;
  assign bus.wr_en   = (r_state == S_WB);
  assign bus.flag_we = (r_state == S_WB) && r_set_flags;
  assign bus.wr_addr = r_dest;
  assign bus.wr_data = r_product[MUL_W-1:0];
  assign bus.product = r_product;
  assign bus.flag_z  = r_flag_z;
  assign bus.flag_n  = r_flag_n;
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed corner cases plus random
// operations compared against an arithmetic reference product.
module tb_mul_sequencer;
  localparam int W = 16;
  localparam int WB_K = W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [2*W-1:0] exp_prod = '0;

  always #5 clk = ~clk;

  mul_sequencer_if #(.MUL_W(W)) bif ();

  mul_sequencer #(.MUL_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [1:0] t, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (t >= 2'd2) begin
      if (a[W-1]) sa = sa - (longint'(1) << W);
      if (b[W-1]) sb = sb - (longint'(1) << W);
    end
    return (2*W)'(sa * sb);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},   64'(bif.stall),   64'd0);
    chk({tag, "_busy"},    64'(bif.busy),    64'd0);
    chk({tag, "_wr_en"},   64'(bif.wr_en),   64'd0);
    chk({tag, "_flag_we"}, 64'(bif.flag_we), 64'd0);
    chk({tag, "_flag_z"},  64'(bif.flag_z),  64'd0);
    chk({tag, "_flag_n"},  64'(bif.flag_n),  64'd0);
    chk({tag, "_wr_addr"}, 64'(bif.wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(bif.wr_data), 64'd0);
    chk({tag, "_product"}, 64'(bif.product), 64'd0);
  endtask

  // One operation, accepted in cycle T; k counts cycles after T.
  // flush_k/retrig_k/rst_k = 0 disables that disturbance.
  task automatic run_op(input logic [1:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] d, input logic sf,
                        input int flush_k, input int retrig_k, input int rst_k);
    logic [2*W-1:0] p;
    bit will_write;
    int wr_cnt, wr_k;
    p = ref_mul(t, a, b);
    will_write = (flush_k == 0 || flush_k >= WB_K) && (rst_k == 0 || rst_k > WB_K);
    wr_cnt = 0;
    wr_k   = 0;
    @(negedge clk);
    bif.mul_type    = t;
    bif.op_a        = a;
    bif.op_b        = b;
    bif.dest_reg    = d;
    bif.set_flags   = sf;
    bif.flush       = 1'b0;
    bif.mul_trigger = 1'b1;
    #1;
    chk("stall_at_accept", 64'(bif.stall), 64'd1);
    chk("busy_at_accept",  64'(bif.busy),  64'd0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (bif.wr_en === 1'b1) begin
        wr_cnt++;
        wr_k = k;
        chk("wb_wr_data", 64'(bif.wr_data), 64'(p[W-1:0]));
        chk("wb_product", 64'(bif.product), 64'(p));
        chk("wb_wr_addr", 64'(bif.wr_addr), 64'(d));
        chk("wb_flag_we", 64'(bif.flag_we), 64'(sf));
        chk("wb_flag_z",  64'(bif.flag_z),  64'(p == '0));
        chk("wb_flag_n",  64'(bif.flag_n),  64'(p[2*W-1]));
      end
      if (k == WB_K + 1 && will_write) begin
        chk("stall_after_wb", 64'(bif.stall), 64'd0);
        chk("busy_after_wb",  64'(bif.busy),  64'd0);
      end
      if (flush_k != 0 && k == flush_k + 1)
        chk("busy_after_flush", 64'(bif.busy), 64'd0);
      if (k == 2)
        chk("busy_in_iter", 64'(bif.busy), 64'd1);
      // Scramble operand inputs to show they were latched at accept
      bif.op_a        = W'($urandom);
      bif.op_b        = W'($urandom);
      bif.dest_reg    = 4'($urandom);
      bif.mul_type    = 2'($urandom);
      bif.set_flags   = 1'($urandom);
      bif.mul_trigger = (k == retrig_k);
      bif.flush       = (k == flush_k);
      if (rst_k != 0 && k == rst_k) begin
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid_op");
      end
      if (rst_k != 0 && k == rst_k + 1) rst = 1'b1;
    end
    bif.mul_trigger = 1'b0;
    bif.flush       = 1'b0;
    if (will_write) exp_prod = p;
    else if (rst_k != 0) exp_prod = '0;
    chk("wr_en_count", 64'(wr_cnt), will_write ? 64'd1 : 64'd0);
    if (will_write) chk("wr_en_latency", 64'(wr_k), 64'(WB_K));
    chk("product_held", 64'(bif.product), 64'(exp_prod));
    chk("idle_at_end", 64'(bif.busy), 64'd0);
  endtask

  initial begin
    logic [1:0]   t;
    logic [W-1:0] a, b;
    bif.mul_trigger = 1'b0;
    bif.mul_type    = '0;
    bif.dest_reg    = '0;
    bif.op_a        = '0;
    bif.op_b        = '0;
    bif.set_flags   = 1'b0;
    bif.flush       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // Directed products
    run_op(2'd1, 16'd3,    16'd5,    4'd7,  1'b0, 0, 0, 0);
    run_op(2'd3, 16'hFFFD, 16'd5,    4'd2,  1'b1, 0, 0, 0);
    run_op(2'd0, 16'hFFFF, 16'hFFFF, 4'd9,  1'b1, 0, 0, 0);
    run_op(2'd2, 16'h8000, 16'h8000, 4'd1,  1'b1, 0, 0, 0);
    run_op(2'd2, 16'h0000, 16'h1234, 4'd15, 1'b1, 0, 0, 0);
    run_op(2'd3, 16'h8000, 16'h7FFF, 4'd4,  1'b1, 0, 0, 0);

    // Retrigger while busy is ignored
    run_op(2'd1, 16'd100, 16'd200, 4'd3, 1'b0, 0, 5, 0);
    // Flush in ITER, in SIGN, and in WB (write completes)
    run_op(2'd1, 16'd7, 16'd9, 4'd5, 1'b1, 8, 0, 0);
    run_op(2'd3, 16'hFFFF, 16'd2, 4'd6, 1'b1, WB_K - 1, 0, 0);
    run_op(2'd0, 16'd11, 16'd13, 4'd8, 1'b1, WB_K, 0, 0);

    // Flush and trigger together in IDLE: no accept
    @(negedge clk);
    bif.mul_trigger = 1'b1;
    bif.flush       = 1'b1;
    @(negedge clk);
    bif.mul_trigger = 1'b0;
    bif.flush       = 1'b0;
    chk("flush_trig_idle_busy", 64'(bif.busy), 64'd0);
    repeat (WB_K + 2) begin
      @(negedge clk);
      chk("flush_trig_no_wr", 64'(bif.wr_en), 64'd0);
    end

    // Asynchronous reset mid-operation
    run_op(2'd1, 16'd21, 16'd2, 4'd10, 1'b1, 0, 0, 10);

    // Random operations with corner-biased operands
    for (int i = 0; i < 24; i++) begin
      t = 2'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      if (i % 4 == 1) a = 16'h8000;
      if (i % 4 == 2) b = 16'hFFFF;
      if (i % 6 == 3) a = 16'h0000;
      run_op(t, a, b, 4'($urandom), 1'($urandom), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter MUL_W, default 16, operand width; product width is 2*MUL_W.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 mul_trigger  in  1  multiply request from decode, level, sampled only in IDLE.
REQ-005 mul_type  in  2  0=muli, 1=mulr, 2=mulsi (signed), 3=mulsr (signed).
REQ-006 dest_reg  in  4  destination register index.
REQ-007 op_a  in  MUL_W  first-source register value.
REQ-008 op_b  in  MUL_W  second-source value (mulr/mulsr) or immediate (muli/mulsi).
REQ-009 set_flags  in  1  update Z/N on completion.
REQ-010 flush  in  1  abort the in-flight multiply, no writeback.
REQ-011 stall  out  1  holds fetch/decode while the multiply is accepted or in flight.
REQ-012 busy  out  1  FSM not in IDLE.
REQ-013 wr_en  out  1  one-cycle register-file write strobe.
REQ-014 wr_addr  out  4  latched dest_reg.
REQ-015 wr_data  out  MUL_W  product low half.
REQ-016 product  out  2*MUL_W  full product, held until the next accept.
REQ-017 flag_we, flag_z, flag_n  out  1 each  flag update strobe, zero (full product), negative (product MSB).

Function
REQ-018 FSM states: IDLE, ITER, SIGN, WB; transitions: IDLE->ITER on accept, ITER->SIGN after MUL_W iterations, SIGN->WB, WB->IDLE.
REQ-019 Accept: in IDLE with mul_trigger=1, latch mul_type, dest_reg, set_flags, and operands in the same edge.
REQ-020 Signed types latch operand magnitudes and the neg = sign(op_a) XOR sign(op_b) bit; unsigned types latch raw operands, neg=0.
REQ-021 Magnitude of -2^(MUL_W-1) is 2^(MUL_W-1) as unsigned; no overflow.
REQ-022 ITER: one shift-add step per cycle; 5-bit counter runs 0..MUL_W-1; accumulator is 2*MUL_W+1 bits, no truncation.
REQ-023 SIGN: two's-complement negate the product if neg=1, otherwise pass it unchanged.
REQ-024 WB: wr_en=1, wr_addr, wr_data and product valid; flag_we=set_flags; asserted for exactly one cycle.
REQ-025 Latency: accept in cycle T -> WB (wr_en) in cycle T+MUL_W+2 (T+18 at default); the next accept is possible in cycle T+MUL_W+3.
REQ-026 stall = busy OR (IDLE AND mul_trigger), combinational; deasserts in the cycle after WB.
REQ-027 mul_trigger while busy is ignored; no queueing.
REQ-028 flush in ITER or SIGN: next state IDLE, no wr_en, no flag_we, product unchanged.
REQ-029 flush in WB is ignored; the write completes.
REQ-030 flush and trigger together in IDLE: flush wins, no accept.

Reset
REQ-031 rst low: state IDLE, counter 0, all latched fields 0.
REQ-032 rst low: stall, busy, wr_en, flag_we, flag_z and flag_n 0; wr_addr, wr_data and product 0.
REQ-033 Reset mid-operation discards the operation with no write; outputs take their reset values immediately.

Structure
REQ-034 Shared package mul_pkg holds the mul_type encodings, the FSM state encoding, and MUL_ITERS=MUL_W.
REQ-035 One sub-module, mul_shift_add_dp (accumulator, multiplicand shift register, negate), is controlled by the FSM in mul_sequencer.

Verification
REQ-036 mulr op_a=3, op_b=5 accepted at T -> at T+18 wr_en=1, wr_data=0x000F, product=0x0000000F.
REQ-037 mulsr op_a=0xFFFD (-3), op_b=5, set_flags=1 -> product=0xFFFFFFF1, wr_data=0xFFF1, flag_n=1, flag_z=0.
REQ-038 muli 0xFFFF x 0xFFFF -> product=0xFFFE0001; mulsi 0x8000 x 0x8000 -> product=0x40000000.
REQ-039 mulsi op_a=0, op_b=0x1234, set_flags=1 -> product=0, flag_we=1, flag_z=1.
REQ-040 Second trigger at T+5 -> ignored; exactly one wr_en in the window T..T+25.
REQ-041 flush at T+8 -> IDLE at T+9, no wr_en; rst low at T+10 of a new op -> all outputs 0 immediately, no write.
